mem_dump_reader: RTL and testbench

Sequential readout engine for the instruction/data RAM's external read port. On a start command it walks a contiguous block of 32-bit little-endian words from a base byte address. Each word is read through the external port and presented on a valid/ready output stream for a debug/UART/testbench consumer. It is the active driver of the RAM's external read interface, which until now has had no on-chip initiator.

---
 rtl/mem_dump_reader.sv | 137 +++++++++++++
 tb/tb_mem_dump_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// Sequential readout engine: walks a block of words through the RAM external read port onto a valid/ready stream.
// Optional checksum output port and accumulator enabled by defining MEM_DUMP_CHECKSUM_EN.
module mem_dump_reader #(
    parameter int ADDR_W    = 16,
    parameter int XLEN      = 32,
    parameter int WORD_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    output logic              busy,
    output logic              done,
    output logic              rd_flag,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]   rd_data,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_data,
    output logic              out_last,
`ifdef MEM_DUMP_CHECKSUM_EN
    output logic [XLEN-1:0]   checksum,
`endif
    input  logic              out_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
    logic [15:0]       remaining_q, remaining_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic              handshake;

    assign handshake = out_valid_q && out_ready;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d  = base_addr;
                    remaining_d = word_count;
                    state_d     = (word_count == 16'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // RAM read data is combinational, so it is captured in the same cycle the address is driven.
                out_data_d  = rd_data;
                out_valid_d = 1'b1;
                out_last_d  = (remaining_q == 16'd1);
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (remaining_q == 16'd1) begin
                        state_d = S_DONE;
                    end else begin
                        remaining_d = remaining_q - 16'd1;
                        cur_addr_d  = cur_addr_q + ADDR_W'(WORD_STEP);
                        state_d     = S_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [XLEN-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start) begin
            checksum_d = '0;
        end else if (state_q == S_HOLD && handshake) begin
            checksum_d = checksum_q + out_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rd_flag   = (state_q == S_REQ);
    assign rd_addr   = cur_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: scoreboard of expected read addresses and output words.
// Covers checksum when MEM_DUMP_CHECKSUM_EN is defined for both bench and design.
module tb_mem_dump_reader;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, rd_flag, out_valid, out_last;
    logic [15:0] rd_addr;
    logic [31:0] rd_data, out_data;
    logic        out_ready = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [0:16383];
    assign rd_data = mem[rd_addr[15:2]];

    mem_dump_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .rd_flag    (rd_flag),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
`ifdef MEM_DUMP_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    logic [15:0] exp_addr_q[$];
    exp_word_t   exp_word_q[$];
    logic [31:0] exp_sum;

    int          rd_cnt, ov_cnt, done_cnt, first_ov, last_hs, done_cycle, start_cycle;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (rd_flag) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else check("rd_addr", {16'd0, rd_addr}, {16'd0, exp_addr_q.pop_front()});
            end
            if (out_valid) begin
                ov_cnt++;
                if (first_ov < 0) first_ov = cycle;
                if (hold_prev) begin
                    check("hold_data", out_data, prev_data);
                    check("hold_last", {31'd0, out_last}, {31'd0, prev_last});
                end
            end
            if (out_valid && out_ready) begin
                if (exp_word_q.size() == 0) begin
                    check("word_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_word_t e;
                    e = exp_word_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", {31'd0, out_last}, {31'd0, e.last});
                end
                last_hs = cycle;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (done) begin
                done_cnt++;
                done_cycle = cycle;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        rd_cnt   = 0;
        ov_cnt   = 0;
        done_cnt = 0;
        first_ov = -1;
        last_hs  = -1;
        done_cycle = -1;
    endtask

    task automatic do_start(input logic [15:0] base, input logic [15:0] count);
        logic [15:0] a;
        @(posedge clk);
        #1;
        start       = 1'b1;
        base_addr   = base;
        word_count  = count;
        start_cycle = cycle;
        exp_sum     = 32'd0;
        a           = base;
        for (int i = 0; i < int'(count); i++) begin
            exp_word_t e;
            e.data = mem[a[15:2]];
            e.last = (i == int'(count) - 1);
            exp_addr_q.push_back(a);
            exp_word_q.push_back(e);
            exp_sum = exp_sum + e.data;
            a = a + 16'd4;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > d0) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) return;
        end
        check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_done"},      {31'd0, done},      32'd0);
        check({tag, "_rd_flag"},   {31'd0, rd_flag},   32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_last"},  {31'd0, out_last},  32'd0);
        check({tag, "_rd_addr"},   {16'd0, rd_addr},   32'd0);
        check({tag, "_out_data"},  out_data,           32'd0);
    endtask

    task automatic check_sb_empty(input string tag);
        check({tag, "_addr_q"}, exp_addr_q.size(), 32'd0);
        check({tag, "_word_q"}, exp_word_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = (i * 32'h01010101) ^ 32'hA5A5_0000;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'hDEAD_BEEF;
        mem[16383] = 32'hCAFE_F00D;
        clr_stats();

        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // Three words, consumer always ready.
        clr_stats();
        out_ready = 1'b1;
        do_start(16'h0000, 16'd3);
        wait_done(40);
        check("t1_first_valid_lat", first_ov - start_cycle, 32'd2);
        check("t1_done_lat", done_cycle - last_hs, 32'd1);
        check("t1_rd_cnt", rd_cnt, 32'd3);
`ifdef MEM_DUMP_CHECKSUM_EN
        check("t1_checksum", checksum, exp_sum);
`endif
        check_sb_empty("t1");
        tick();
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // Empty transfer.
        clr_stats();
        do_start(16'h0040, 16'd0);
        wait_done(10);
        check("t2_done_lat", done_cycle - start_cycle, 32'd1);
        repeat (3) tick();
        check("t2_rd_cnt", rd_cnt, 32'd0);
        check("t2_ov_cnt", ov_cnt, 32'd0);
        check("t2_done_cnt", done_cnt, 32'd1);

        // Backpressure on the first word.
        clr_stats();
        out_ready = 1'b0;
        do_start(16'h0000, 16'd2);
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_rd_flag", {31'd0, rd_flag}, 32'd0);
            check("t3_hold_addr", {16'd0, rd_addr}, 32'd0);
            check("t3_hold_data", out_data, mem[0]);
            check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            if (i < 4) begin
                @(negedge clk);
                #1;
            end
        end
        tick();
        out_ready = 1'b1;
        wait_done(20);
        check("t3_rd_cnt", rd_cnt, 32'd2);
        check_sb_empty("t3");

        // Address wrap at the top of the space.
        clr_stats();
        do_start(16'hFFFC, 16'd2);
        wait_done(20);
        check("t4_rd_cnt", rd_cnt, 32'd2);
        check_sb_empty("t4");
`ifdef MEM_DUMP_CHECKSUM_EN
        check("t4_checksum", checksum, exp_sum);
`endif

        // Reset while holding word 1 of 4.
        clr_stats();
        out_ready = 1'b0;
        do_start(16'h0020, 16'd4);
        wait_valid(10);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid(10);
        check("t5_in_word1", ov_cnt > 1, 32'd1);
        tick();
        rst = 1'b1;
        exp_addr_q.delete();
        exp_word_q.delete();
        tick();
        check_idle("t5_after_rst");
        rst = 1'b0;
        repeat (3) tick();
        check("t5_no_done", done_cnt, 32'd0);
        clr_stats();
        out_ready = 1'b1;
        do_start(16'h0000, 16'd2);
        wait_done(20);
        check("t5_rd_cnt", rd_cnt, 32'd2);
        check_sb_empty("t5");

        // Start re-pulsed while busy is ignored.
        clr_stats();
        do_start(16'h0040, 16'd3);
        tick();
        start      = 1'b1;
        base_addr  = 16'h0100;
        word_count = 16'd5;
        tick();
        start = 1'b0;
        wait_done(40);
        repeat (3) tick();
        check("t6_busy_after", {31'd0, busy}, 32'd0);
        check("t6_rd_cnt", rd_cnt, 32'd3);
        check("t6_done_cnt", done_cnt, 32'd1);
        check_sb_empty("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
